alu_wide_seq: RTL and testbench
===============================

Name: alu_wide_seq

Overview:
- Multi-precision sequencer that drives the 8-bit ALU command interface (alu_cmd, inA, inB, sc_i) and consumes its outputs (rslt, sc_o, zero, pari).
- Performs NBYTES-wide add, subtract, shift-left and shift-right, one byte per cycle, chaining the carry through sc_i/sc_o.
- Sits between the control unit and the ALU for wide-operand instructions; the ALU itself stays unchanged.

Parameters:
- NBYTES, 2, operand width in bytes (legal range 2..8); the operand/result width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 CMP (only with the optional feature), others illegal
- opa  input  W  operand A, sampled on the accepting edge
- opb  input  W  operand B, sampled on the accepting edge (ignored for shifts)
- busy  output  1  high from the accepting edge until done has been issued
- done  output  1  single-cycle pulse; the results are valid from this cycle onward
- result  output  W  wide result, held until the next accepted op
- carry  output  1  final ALU sc_o (SUB/CMP: 1 = no borrow)
- zero  output  1  1 when the whole W-bit result is zero
- parity  output  1  XOR of all W result bits
- alu_cmd  output  3  to the ALU: 000 add, 001 left shift, 010 right shift
- alu_a  output  8  to ALU inA
- alu_b  output  8  to ALU inB
- alu_sc  output  1  to ALU sc_i
- alu_rslt  input  8  from ALU rslt
- alu_sc_o  input  1  from ALU sc_o
- alu_zero  input  1  from ALU zero

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, result, carry, zero and parity are 0. alu_cmd is 000; alu_a, alu_b and alu_sc are 0.
- States:
  - IDLE -> RUN on start=1 with a legal op. That edge latches opa, opb and op, sets byte index k=0, zero accumulator=1, carry latch=initial carry.
  - RUN: for exactly NBYTES cycles, drive the ALU combinationally from the latched state.
    - Each edge writes alu_rslt into result byte k, latches alu_sc_o as the next alu_sc, ANDs alu_zero into the accumulator, and advances k.
    - After the NBYTES-th edge, go to DONE.
  - DONE: done=1 for one cycle, busy=1. Then go to IDLE, busy=0.
  - Latency: done is high in cycle NBYTES+1 after the accepting edge. Back-to-back throughput is one op per NBYTES+2 cycles.
- Byte order and ALU drive per op:
  - ADD: LSB first; alu_cmd=000, alu_b=B byte, initial alu_sc=0.
  - SUB: LSB first; alu_cmd=000, alu_b=~B byte, initial alu_sc=1 (two's complement). The ALU SUB code is not used.
  - SHL: LSB first; alu_cmd=001, alu_b=0, initial alu_sc=0.
  - SHR: MSB first; alu_cmd=010, alu_b=0, initial alu_sc=0. Result byte index runs NBYTES-1 down to 0.
- Flag outputs:
  - carry = last alu_sc_o.
  - zero = accumulator.
  - parity = XOR-reduce of the final result.
  - All three update on the same edge that enters DONE.
- Outside RUN: alu_cmd=000 and alu_a, alu_b, alu_sc are 0.
- start while busy=1: ignored, with no effect on the op in flight.
- Illegal op at start: not accepted; busy stays 0 and done never fires.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded.
- A start coincident with the DONE cycle is ignored. It is accepted from IDLE on the next cycle.

Optional Feature:
- Macro: ALU_WIDE_SEQ_CMP_EN.
- Defined: op 100 is CMP. It sequences exactly like SUB and updates carry, zero and parity (parity computed from the internal difference). The result register keeps its previous value; done pulses as normal.
- Undefined: op 100 is illegal and handled as described under Behaviour.

Test Plan:
- NBYTES=2, ADD 0x00FF+0x0001 -> done in cycle 3 after start; result=0x0100, carry=0, zero=0, parity=1.
- ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1, parity=0.
- SUB 0x1234-0x1234 -> result=0x0000, carry=1, zero=1. SUB 0x0000-0x0001 -> result=0xFFFF, carry=0, parity=0.
- SHL 0x8001 -> result=0x0002, carry=1. SHR 0x0003 -> result=0x0001, carry=1, with alu_cmd=010 seen during RUN.
- Second start during RUN and illegal op 101 from IDLE -> ignored; exactly one done per accepted op. rst_n low in the second RUN cycle -> all outputs 0 asynchronously.
- With ALU_WIDE_SEQ_CMP_EN: ADD 0x00FF+0x0001, then CMP 0x0005 vs 0x0007 -> result stays 0x0100, carry=0, zero=0. Without the macro, op 100 -> busy stays 0.

Source files
------------

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences NBYTES-wide ADD/SUB/SHL/SHR through an external 8-bit ALU, one byte per cycle.
// Optional: define ALU_WIDE_SEQ_CMP_EN to enable op 100 (CMP: updates flags only, result is kept).
module alu_wide_seq #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic                  parity,
    output logic [2:0]            alu_cmd,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_sc,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sc_o,
    input  logic                  alu_zero
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
`ifdef ALU_WIDE_SEQ_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_CMP = 3'b100
    } op_t;

    state_t        state;
    op_t           op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  work_q;
    logic [W-1:0]  work_nxt;
    logic [IW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic          sc_q;
    logic          zacc;
    logic          op_legal;
    logic          sub_like;

    assign op_legal = (op <= 3'b011) || (CMP_EN && (op == 3'b100));
    assign sub_like = (op_q == OP_SUB) || (op_q == OP_CMP);
    // SHR walks from the top byte down so each byte's shifted-out bit feeds the next lower byte.
    assign idx      = (op_q == OP_SHR) ? LAST - cnt : cnt;
    assign a_byte   = a_q[{idx, 3'b000} +: 8];
    assign b_byte   = b_q[{idx, 3'b000} +: 8];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        alu_cmd  = 3'b000;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_sc   = 1'b0;
        work_nxt = work_q;
        if (state == RUN) begin
            alu_a  = a_byte;
            alu_sc = sc_q;
            case (op_q)
                OP_SHL:  alu_cmd = 3'b001;
                OP_SHR:  alu_cmd = 3'b010;
                default: alu_b   = sub_like ? ~b_byte : b_byte;
            endcase
            work_nxt[{idx, 3'b000} +: 8] = alu_rslt;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            work_q <= '0;
            cnt    <= '0;
            sc_q   <= 1'b0;
            zacc   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            parity <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && op_legal) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        op_q  <= op_t'(op);
                        a_q   <= opa;
                        b_q   <= opb;
                        cnt   <= '0;
                        zacc  <= 1'b1;
                        // Two's-complement subtract: A + ~B + 1, the +1 entering as the first carry.
                        sc_q  <= (op == 3'b001) || (op == 3'b100);
                    end
                end
                RUN: begin
                    work_q <= work_nxt;
                    sc_q   <= alu_sc_o;
                    zacc   <= zacc & alu_zero;
                    cnt    <= cnt + IW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        carry  <= alu_sc_o;
                        zero   <= zacc & alu_zero;
                        parity <= ^work_nxt;
                        if (op_q != OP_CMP) begin
                            result <= work_nxt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: models the 8-bit ALU, predicts wide results with plain arithmetic,
// compares every cycle and pins the model with hand-computed directed results.
module tb_alu_wide_seq;
    localparam int NBYTES = 2;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic          parity;
    logic [2:0]    alu_cmd;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_sc;
    logic [7:0]    alu_rslt;
    logic          alu_sc_o;
    logic          alu_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    always #5 clk = ~clk;

    alu_wide_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .parity(parity),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc(alu_sc),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_zero(alu_zero)
    );

    // The unchanged 8-bit ALU: add with carry, shift left/right through the carry.
    always_comb begin
        case (alu_cmd)
            3'b001:  {alu_sc_o, alu_rslt} = {alu_a, alu_sc};
            3'b010:  {alu_rslt, alu_sc_o} = {alu_sc, alu_a};
            default: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc};
        endcase
        alu_zero = (alu_rslt == 8'h00);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit op_legal(input logic [2:0] o);
`ifdef ALU_WIDE_SEQ_CMP_EN
        return o <= 3'd4;
`else
        return o <= 3'd3;
`endif
    endfunction

    // Reference model: cycles left in the op plus the wide answer computed up front.
    int           m_left   = 0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_result = '0;
    logic         m_carry  = 1'b0;
    logic         m_zero   = 1'b0;
    logic         m_parity = 1'b0;
    logic [2:0]   m_cmd    = 3'b000;
    logic [W-1:0] p_result = '0;
    logic [W-1:0] p_diff   = '0;
    logic         p_carry  = 1'b0;
    logic         p_zero   = 1'b0;
    logic         p_parity = 1'b0;
    bit           p_keep   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_result = '0;
            m_carry = 1'b0; m_zero = 1'b0; m_parity = 1'b0;
        end else if (m_left == 0) begin
            if (start && op_legal(op)) begin
                m_left = NBYTES + 1;
                p_keep = 1'b0;
                m_cmd  = 3'b000;
                case (op)
                    3'd0: {p_carry, p_result} = {1'b0, opa} + {1'b0, opb};
                    3'd1: begin p_result = opa - opb; p_carry = (opa >= opb); end
                    3'd2: begin p_result = opa << 1; p_carry = opa[W-1]; m_cmd = 3'b001; end
                    3'd3: begin p_result = opa >> 1; p_carry = opa[0];   m_cmd = 3'b010; end
                    default: begin p_result = opa - opb; p_carry = (opa >= opb); p_keep = 1'b1; end
                endcase
                p_diff   = p_result;
                p_zero   = (p_diff == '0);
                p_parity = ^p_diff;
            end
        end else begin
            m_left--;
            m_done = (m_left == 1);
            if (m_done) begin
                if (!p_keep) m_result = p_result;
                m_carry = p_carry; m_zero = p_zero; m_parity = p_parity;
            end
        end
    end

    always @(negedge clk) begin
        if (done) n_done++;
        check("busy", busy, m_left != 0);
        check("done", done, m_done);
        check("flags", {carry, zero, parity}, {m_carry, m_zero, m_parity});
        if (m_left <= 1) begin
            check("result", result, m_result);
            check("alu_idle", {alu_cmd, alu_a, alu_b, alu_sc}, '0);
        end else begin
            check("alu_cmd", alu_cmd, m_cmd);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit stray, output int lat, output bit saw_shr);
        saw_shr = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        lat   = 1;
        start = stray;
        if (stray) begin op = 3'd1; opa = '1; opb = W'(1); end
        while (!done && lat < 20) begin
            if (busy && alu_cmd == 3'b010) saw_shr = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", done, 1'b1);
    endtask

    initial begin
        int lat;
        bit saw;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; opa = '0; opb = '0;
        #1 check("reset_state",
                 {busy, done, result, carry, zero, parity, alu_cmd, alu_a, alu_b, alu_sc}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, lat, saw);
        check("add1_latency", lat, NBYTES + 1);
        check("add1_result", result, 16'h0100);
        check("add1_flags", {carry, zero, parity}, 3'b001);

        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, lat, saw);
        check("add2_result", result, 16'h0000);
        check("add2_flags", {carry, zero, parity}, 3'b110);

        run_op(3'd1, 16'h1234, 16'h1234, 1'b0, lat, saw);
        check("sub1_result", result, 16'h0000);
        check("sub1_flags", {carry, zero, parity}, 3'b110);

        run_op(3'd1, 16'h0000, 16'h0001, 1'b0, lat, saw);
        check("sub2_result", result, 16'hFFFF);
        check("sub2_flags", {carry, zero, parity}, 3'b000);

        run_op(3'd2, 16'h8001, 16'hFFFF, 1'b0, lat, saw);
        check("shl_result", result, 16'h0002);
        check("shl_flags", {carry, zero, parity}, 3'b101);

        run_op(3'd3, 16'h0003, 16'hFFFF, 1'b0, lat, saw);
        check("shr_result", result, 16'h0001);
        check("shr_flags", {carry, zero, parity}, 3'b101);
        check("shr_cmd_seen", saw, 1'b1);

        run_op(3'd1, 16'h8000, 16'h0001, 1'b0, lat, saw);
        check("sub3_result", result, 16'h7FFF);
        check("sub3_flags", {carry, zero, parity}, 3'b101);

        // Second start arrives mid-RUN and must not disturb the op in flight.
        run_op(3'd0, 16'h1111, 16'h2222, 1'b1, lat, saw);
        check("stray_result", result, 16'h3333);
        check("stray_flags", {carry, zero, parity}, 3'b000);

        // Start held only during the DONE cycle is dropped.
        start = 1'b1; op = 3'd0; opa = 16'h0001; opb = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start_ignored", busy, 1'b0);
        @(negedge clk);
        check("done_cycle_start_still_idle", busy, 1'b0);

        start = 1'b1; op = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("illegal_op_busy", busy, 1'b0);
            check("illegal_op_done", done, 1'b0);
        end

`ifdef ALU_WIDE_SEQ_CMP_EN
        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, lat, saw);
        check("pre_cmp_result", result, 16'h0100);
        run_op(3'd4, 16'h0005, 16'h0007, 1'b0, lat, saw);
        check("cmp_result_kept", result, 16'h0100);
        check("cmp_flags", {carry, zero, parity}, 3'b001);
`else
        @(negedge clk);
        start = 1'b1; op = 3'd4; opa = 16'h0005; opb = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("cmp_disabled_busy", busy, 1'b0);
        end
`endif

        // Reset in the second RUN cycle clears everything without waiting for a clock.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 16'h00FF; opb = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_midrun",
                 {busy, done, result, carry, zero, parity, alu_cmd, alu_a, alu_b, alu_sc}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 16'h0001, 16'h0001, 1'b0, lat, saw);
        check("recover_result", result, 16'h0002);
        check("recover_flags", {carry, zero, parity}, 3'b001);

        repeat (3) @(negedge clk);
`ifdef ALU_WIDE_SEQ_CMP_EN
        check("done_pulse_count", n_done, 11);
`else
        check("done_pulse_count", n_done, 9);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
